alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
Mode/alarm controller for the BCD watch core and 7-segment scanner. It sequences time setting and alarm setting from debounced button pulses, and issues a one-cycle load of the new time into the watch. It compares the running time against a stored alarm and drives the buzzer with a ring timeout and a snooze. It also selects which four BCD digits the display scanner shows.

Parameters:
RING_SECS, 60, number of sec_tick strobes the buzzer rings before auto-stop (must be ≥1)
SNOOZE_SECS, 300, number of sec_tick strobes spent in snooze before re-ringing (must be ≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset, synchronous, active-low
sec_tick  in  1  one-cycle 1 Hz strobe
btn_mode  in  1  debounced one-cycle pulse, advance mode
btn_inc  in  1  debounced one-cycle pulse, increment field / snooze
btn_alarm  in  1  debounced one-cycle pulse, toggle alarm enable / stop ring
hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  running time from watch core, BCD
hourdec_set, hourone_set, mindec_set, minone_set  out  4 each  time to load into watch (edit registers)
time_load  out  1  one-cycle pulse: watch loads *_set values
disp_hourdec, disp_hourone, disp_mindec, disp_minone  out  4 each  digits for display scanner
mode  out  3  current state code
alarm_en  out  1  alarm armed
buzzer  out  1  high while ringing

Behaviour:
- Reset (rstn=0 at clk edge):
  - state RUN; alarm_en=0; buzzer=0; time_load=0.
  - Edit time registers (*_set) = 0:00; alarm registers = 0:00.
  - Second counter = 0; match-history flag = 0.
- State codes: RUN=0, SET_TH=1, SET_TM=2, SET_AH=3, SET_AM=4, RING=5, SNOOZE=6. Codes 7 and any illegal value go to RUN.
- Button priority when pulses coincide: btn_alarm > btn_mode > btn_inc. Only the highest-priority pulse acts.
- Mode sequencing:
  - RUN: btn_mode → SET_TH and copies all *_now digits into the edit registers in the same cycle. btn_alarm toggles alarm_en.
  - SET_TH: btn_mode → SET_TM. btn_inc does the hour increment.
  - SET_TM: btn_mode → SET_AH and asserts time_load for exactly that one cycle (registered; high the cycle after the btn_mode edge). btn_inc does the minute increment on the edit registers.
  - SET_AH: btn_mode → SET_AM. btn_inc does the hour increment on the alarm registers.
  - SET_AM: btn_mode → RUN. btn_inc does the minute increment on the alarm registers.
  - btn_alarm in any SET_* state toggles alarm_en only; the state is unchanged.
- Hour increment (BCD):
  - 2:3 → 0:0.
  - Ones digit = 9 → ones 0, tens +1.
  - Otherwise ones +1.
- Minute increment (BCD):
  - 5:9 → 0:0, with no carry into the hour.
  - Ones digit = 9 → ones 0, tens +1.
  - Otherwise ones +1.
- Match detection:
  - match = (all four *_now digits == alarm digits) & alarm_en.
  - A RING trigger is match=1 while the match-history flag=0; the flag holds the previous cycle's match.
  - A trigger acts only in RUN. Triggers arriving in SET_* states are ignored.
  - Stopping a ring does not retrigger within the same matching minute.
- RING:
  - buzzer=1; the counter increments on each sec_tick.
  - When the counter reaches RING_SECS → RUN, counter cleared.
  - btn_alarm → RUN, counter cleared; alarm_en stays 1.
  - btn_inc → SNOOZE, counter cleared.
  - btn_mode is ignored.
- SNOOZE:
  - buzzer=0; the counter increments on each sec_tick.
  - When the counter reaches SNOOZE_SECS → RING, counter cleared.
  - btn_alarm → RUN, counter cleared.
- alarm_en cleared while in RING or SNOOZE (impossible through the buttons in these states; defined for completeness) → RUN.
- Counter width: enough bits to hold max(RING_SECS, SNOOZE_SECS).
- buzzer is a registered output, equal to (state==RING).
- Display selection (combinational):
  - RUN, RING, SNOOZE: disp_* = *_now.
  - SET_TH, SET_TM: disp_* = edit registers.
  - SET_AH, SET_AM: disp_* = alarm registers.
- Reset mid-operation (any state, including RING): the next edge returns everything to the reset values; buzzer=0 on that edge.

Test Plan:
1. Reset, then RUN with now=12:34 → disp=12:34, mode=0, buzzer=0, alarm_en=0, time_load=0.
2. btn_mode from RUN with now=23:58; btn_inc ×1 in SET_TH → edit hour 00; btn_mode; btn_inc ×2 in SET_TM → edit minute 00 (58→59→00, hour stays 00); btn_mode → time_load high exactly one cycle, *_set=00:00, mode=3.
3. Set the alarm to 07:00 from 00:00 (btn_inc ×7 in SET_AH, then btn_mode twice) → alarm regs 07:00, mode=0. Press btn_alarm → alarm_en=1. Drive now=07:00 → RING, buzzer=1 within 1 cycle. Hold now=07:00 and press btn_alarm → RUN, buzzer=0, no re-ring while now stays 07:00.
4. With RING_SECS=3, trigger RING then apply 3 sec_ticks → buzzer drops after the 3rd tick, mode=0.
5. With SNOOZE_SECS=2 in RING, press btn_inc → SNOOZE, buzzer=0. After 2 sec_ticks → RING, buzzer=1. Then btn_alarm → RUN.
6. btn_alarm+btn_mode same cycle in RUN → alarm_en toggles, mode stays 0. Pulse rstn=0 during RING → next edge buzzer=0, mode=0, alarm regs 00:00.

Source files
------------

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - mode/alarm controller: time and alarm setting, ring/snooze, display select
module alarm_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sec_tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alarm,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   output logic [3:0] hourdec_set,
   output logic [3:0] hourone_set,
   output logic [3:0] mindec_set,
   output logic [3:0] minone_set,
   output logic       time_load,
   output logic [3:0] disp_hourdec,
   output logic [3:0] disp_hourone,
   output logic [3:0] disp_mindec,
   output logic [3:0] disp_minone,
   output logic [2:0] mode,
   output logic       alarm_en,
   output logic       buzzer
);

   localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RING_LIM   = CW'(RING_SECS);
   localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_SECS);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_TH = 3'd1,
      SET_TM = 3'd2,
      SET_AH = 3'd3,
      SET_AM = 3'd4,
      RING   = 3'd5,
      SNOOZE = 3'd6
   } state_t;

   state_t        state;
   logic [3:0]    alm_hourdec, alm_hourone, alm_mindec, alm_minone;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          match_hist;
   logic          match;
   logic          trigger;
   logic          p_alarm, p_mode, p_inc;

   function automatic logic [7:0] hour_inc(input logic [3:0] dec, input logic [3:0] one);
      if (dec == 4'd2 && one == 4'd3)
         return 8'h00;
      else if (one == 4'd9)
         return {dec + 4'd1, 4'd0};
      else
         return {dec, one + 4'd1};
   endfunction

   // minutes wrap without carrying into the hour field
   function automatic logic [7:0] min_inc(input logic [3:0] dec, input logic [3:0] one);
      if (dec == 4'd5 && one == 4'd9)
         return 8'h00;
      else if (one == 4'd9)
         return {dec + 4'd1, 4'd0};
      else
         return {dec, one + 4'd1};
   endfunction

   assign p_alarm = btn_alarm;
   assign p_mode  = btn_mode & ~btn_alarm;
   assign p_inc   = btn_inc & ~btn_mode & ~btn_alarm;

   assign match   = alarm_en &&
                    ({hourdec_now, hourone_now, mindec_now, minone_now} ==
                     {alm_hourdec, alm_hourone, alm_mindec, alm_minone});
   assign trigger = match & ~match_hist;
   assign cnt_nxt = cnt + 1'b1;
   assign mode    = state;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= RUN;
         alarm_en    <= 1'b0;
         buzzer      <= 1'b0;
         time_load   <= 1'b0;
         hourdec_set <= 4'd0;
         hourone_set <= 4'd0;
         mindec_set  <= 4'd0;
         minone_set  <= 4'd0;
         alm_hourdec <= 4'd0;
         alm_hourone <= 4'd0;
         alm_mindec  <= 4'd0;
         alm_minone  <= 4'd0;
         cnt         <= '0;
         match_hist  <= 1'b0;
      end else begin
         time_load  <= 1'b0;
         match_hist <= match;
         case (state)
            RUN: begin
               // an alarm trigger pre-empts any button pressed in the same cycle
               if (trigger) begin
                  state  <= RING;
                  cnt    <= '0;
                  buzzer <= 1'b1;
               end else if (p_alarm) begin
                  alarm_en <= ~alarm_en;
               end else if (p_mode) begin
                  hourdec_set <= hourdec_now;
                  hourone_set <= hourone_now;
                  mindec_set  <= mindec_now;
                  minone_set  <= minone_now;
                  state       <= SET_TH;
               end
            end
            SET_TH: begin
               if (p_alarm)
                  alarm_en <= ~alarm_en;
               else if (p_mode)
                  state <= SET_TM;
               else if (p_inc)
                  {hourdec_set, hourone_set} <= hour_inc(hourdec_set, hourone_set);
            end
            SET_TM: begin
               if (p_alarm) begin
                  alarm_en <= ~alarm_en;
               end else if (p_mode) begin
                  state     <= SET_AH;
                  time_load <= 1'b1;
               end else if (p_inc) begin
                  {mindec_set, minone_set} <= min_inc(mindec_set, minone_set);
               end
            end
            SET_AH: begin
               if (p_alarm)
                  alarm_en <= ~alarm_en;
               else if (p_mode)
                  state <= SET_AM;
               else if (p_inc)
                  {alm_hourdec, alm_hourone} <= hour_inc(alm_hourdec, alm_hourone);
            end
            SET_AM: begin
               if (p_alarm)
                  alarm_en <= ~alarm_en;
               else if (p_mode)
                  state <= RUN;
               else if (p_inc)
                  {alm_mindec, alm_minone} <= min_inc(alm_mindec, alm_minone);
            end
            RING: begin
               if (!alarm_en || p_alarm) begin
                  state  <= RUN;
                  cnt    <= '0;
                  buzzer <= 1'b0;
               end else if (p_inc) begin
                  state  <= SNOOZE;
                  cnt    <= '0;
                  buzzer <= 1'b0;
               end else if (sec_tick) begin
                  if (cnt_nxt == RING_LIM) begin
                     state  <= RUN;
                     cnt    <= '0;
                     buzzer <= 1'b0;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end
            end
            SNOOZE: begin
               if (!alarm_en || p_alarm) begin
                  state <= RUN;
                  cnt   <= '0;
               end else if (sec_tick) begin
                  if (cnt_nxt == SNOOZE_LIM) begin
                     state  <= RING;
                     cnt    <= '0;
                     buzzer <= 1'b1;
                  end else begin
                     cnt <= cnt_nxt;
                  end
               end
            end
            default: begin
               state  <= RUN;
               cnt    <= '0;
               buzzer <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      disp_hourdec = hourdec_now;
      disp_hourone = hourone_now;
      disp_mindec  = mindec_now;
      disp_minone  = minone_now;
      case (state)
         SET_TH, SET_TM: begin
            disp_hourdec = hourdec_set;
            disp_hourone = hourone_set;
            disp_mindec  = mindec_set;
            disp_minone  = minone_set;
         end
         SET_AH, SET_AM: begin
            disp_hourdec = alm_hourdec;
            disp_hourone = alm_hourone;
            disp_mindec  = alm_mindec;
            disp_minone  = alm_minone;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - bench for alarm_ctrl against an integer-time behavioural model
module tb_alarm_ctrl;

   localparam int RS = 3;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       sec_tick = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_alarm = 1'b0;
   logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
   logic [3:0] hourdec_set, hourone_set, mindec_set, minone_set;
   logic       time_load;
   logic [3:0] disp_hourdec, disp_hourone, disp_mindec, disp_minone;
   logic [2:0] mode;
   logic       alarm_en;
   logic       buzzer;

   int vectors = 0;
   int miscompares = 0;
   int now_h = 12;
   int now_m = 34;

   // model state: times kept as plain hour/minute integers
   int m_state = 0;
   int e_h = 0, e_m = 0, a_h = 0, a_m = 0, cnt = 0;
   bit m_en = 0, m_buz = 0, m_tl = 0, m_hist = 0;

   assign hourdec_now = 4'(now_h / 10);
   assign hourone_now = 4'(now_h % 10);
   assign mindec_now  = 4'(now_m / 10);
   assign minone_now  = 4'(now_m % 10);

   alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
      .clk(clk), .rstn(rstn), .sec_tick(sec_tick),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
      .hourdec_now(hourdec_now), .hourone_now(hourone_now),
      .mindec_now(mindec_now), .minone_now(minone_now),
      .hourdec_set(hourdec_set), .hourone_set(hourone_set),
      .mindec_set(mindec_set), .minone_set(minone_set),
      .time_load(time_load),
      .disp_hourdec(disp_hourdec), .disp_hourone(disp_hourone),
      .disp_mindec(disp_mindec), .disp_minone(disp_minone),
      .mode(mode), .alarm_en(alarm_en), .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bcd(input int h, input int m);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step;
      bit match, pa, pm, pi;
      if (!rstn) begin
         m_state = 0; e_h = 0; e_m = 0; a_h = 0; a_m = 0; cnt = 0;
         m_en = 0; m_buz = 0; m_tl = 0; m_hist = 0;
         return;
      end
      match = m_en && now_h == a_h && now_m == a_m;
      pa = btn_alarm;
      pm = btn_mode && !btn_alarm;
      pi = btn_inc && !btn_mode && !btn_alarm;
      m_tl = 0;
      case (m_state)
         0: if (match && !m_hist) begin m_state = 5; cnt = 0; end
            else if (pa) m_en = !m_en;
            else if (pm) begin e_h = now_h; e_m = now_m; m_state = 1; end
         1: if (pa) m_en = !m_en; else if (pm) m_state = 2; else if (pi) e_h = (e_h + 1) % 24;
         2: if (pa) m_en = !m_en; else if (pm) begin m_state = 3; m_tl = 1; end
            else if (pi) e_m = (e_m + 1) % 60;
         3: if (pa) m_en = !m_en; else if (pm) m_state = 4; else if (pi) a_h = (a_h + 1) % 24;
         4: if (pa) m_en = !m_en; else if (pm) m_state = 0; else if (pi) a_m = (a_m + 1) % 60;
         5: if (pa || !m_en) begin m_state = 0; cnt = 0; end
            else if (pi) begin m_state = 6; cnt = 0; end
            else if (sec_tick) begin
               cnt++;
               if (cnt == RS) begin m_state = 0; cnt = 0; end
            end
         6: if (pa || !m_en) begin m_state = 0; cnt = 0; end
            else if (sec_tick) begin
               cnt++;
               if (cnt == SS) begin m_state = 5; cnt = 0; end
            end
         default: m_state = 0;
      endcase
      m_hist = match;
      m_buz = (m_state == 5);
   endtask

   task automatic check_all;
      logic [15:0] exp_disp;
      if (m_state == 1 || m_state == 2) exp_disp = bcd(e_h, e_m);
      else if (m_state == 3 || m_state == 4) exp_disp = bcd(a_h, a_m);
      else exp_disp = bcd(now_h, now_m);
      check("mode", 16'(mode), 16'(m_state));
      check("alarm_en", 16'(alarm_en), 16'(m_en));
      check("buzzer", 16'(buzzer), 16'(m_buz));
      check("time_load", 16'(time_load), 16'(m_tl));
      check("set", {hourdec_set, hourone_set, mindec_set, minone_set}, bcd(e_h, e_m));
      check("disp", {disp_hourdec, disp_hourone, disp_mindec, disp_minone}, exp_disp);
   endtask

   task automatic step(input bit a, input bit md, input bit inc, input bit tk, input bit r = 1'b1);
      @(negedge clk);
      btn_alarm = a; btn_mode = md; btn_inc = inc; sec_tick = tk; rstn = r;
      @(posedge clk);
      model_step();
      #1 check_all();
   endtask

   function automatic logic [15:0] disp_w();
      return {disp_hourdec, disp_hourone, disp_mindec, disp_minone};
   endfunction

   initial begin
      // reset and idle display
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("p1_disp", disp_w(), 16'h1234);
      check("p1_mode", 16'(mode), 16'd0);
      check("p1_buzzer", 16'(buzzer), 16'd0);

      // time setting with hour and minute wrap
      now_h = 23; now_m = 58;
      step(0, 1, 0, 0);
      check("p2_mode_th", 16'(mode), 16'd1);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      check("p2_time_load", 16'(time_load), 16'd1);
      check("p2_set", {hourdec_set, hourone_set, mindec_set, minone_set}, 16'h0000);
      check("p2_mode_ah", 16'(mode), 16'd3);
      step(0, 0, 0, 0);
      check("p2_time_load_drop", 16'(time_load), 16'd0);

      // alarm to 07:00, arm, ring, stop
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      check("p3_alarm_regs", disp_w(), 16'h0700);
      step(0, 1, 0, 0);
      check("p3_mode_run", 16'(mode), 16'd0);
      step(1, 0, 0, 0);
      check("p3_alarm_en", 16'(alarm_en), 16'd1);
      now_h = 7; now_m = 0;
      step(0, 0, 0, 0);
      check("p3_ring", 16'(buzzer), 16'd1);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("p3_stop", 16'(buzzer), 16'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      check("p3_no_rering", 16'(mode), 16'd0);

      // ring timeout after RS ticks
      now_m = 1; step(0, 0, 0, 0);
      now_m = 0; step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("p4_ring_held", 16'(buzzer), 16'd1);
      step(0, 0, 0, 1);
      check("p4_timeout_buz", 16'(buzzer), 16'd0);
      check("p4_timeout_mode", 16'(mode), 16'd0);

      // snooze and re-ring
      now_m = 1; step(0, 0, 0, 0);
      now_m = 0; step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check("p5_snooze", 16'(mode), 16'd6);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("p5_rering", 16'(buzzer), 16'd1);
      step(1, 0, 0, 0);
      check("p5_stop", 16'(mode), 16'd0);

      // coincident buttons, reset during ring
      step(1, 1, 0, 0);
      check("p6_toggle", 16'(alarm_en), 16'd0);
      check("p6_mode", 16'(mode), 16'd0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      check("p6_ring", 16'(mode), 16'd5);
      step(0, 0, 0, 0, 0);
      check("p6_rst_buz", 16'(buzzer), 16'd0);
      check("p6_rst_mode", 16'(mode), 16'd0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("p6_alarm_cleared", disp_w(), 16'h0000);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) begin
            if ($urandom_range(2) != 0) begin
               now_h = a_h; now_m = a_m;
            end else begin
               now_h = int'($urandom_range(23)); now_m = int'($urandom_range(59));
            end
         end
         step($urandom_range(11) == 0, $urandom_range(9) == 0, $urandom_range(5) == 0,
              $urandom_range(2) == 0, $urandom_range(399) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
